// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the IF-stage fetch/redirect unit.
package fetch_redirect_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Word-align a redirect target; masking keeps every input bit in the cone.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory request/response channel between fetch unit and imem.
interface fetch_redirect_unit_if;
  import fetch_redirect_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, inst} holding slot for words fetched while ID is stalled.
module fetch_skid_buffer
  import fetch_redirect_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);

  // Clear (redirect) wins over push, push over pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC owner: issues imem fetches, applies EX redirects, and feeds the IF/ID register
// through a one-entry skid buffer so ID stalls never drop an accepted word.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  jump_flag,
  input  logic [XLEN-1:0]       jump_target,
  fetch_redirect_unit_if.master imem,
  output logic                  if_valid,
  output logic [XLEN-1:0]       if_pc,
  output logic [XLEN-1:0]       if_inst,
  output logic                  flush
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            if_valid_d;
  logic [XLEN-1:0] if_pc_d, if_inst_d;

  logic            accept;
  logic            skid_push, skid_pop, skid_clear, skid_full;
  fetch_entry_t    skid_in, skid_out;

  assign accept          = req_q & imem.imem_ready;
  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign flush           = jump_flag;
  assign skid_in         = '{pc: addr_q, inst: imem.imem_rdata};

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (skid_clear),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (skid_in),
    .full  (skid_full),
    .dout  (skid_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      if_valid <= if_valid_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
    end
  end

  // Next-state, PC and IF/ID update; a redirect overrides stall, skid and any accepted word.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc;
    if_inst_d  = NOP_INST;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (jump_flag) begin
      pc_d       = align_pc(jump_target);
      skid_clear = 1'b1;
      case (state_q)
        IF_REQ, IF_DISCARD: state_d = accept ? IF_REQ : IF_DISCARD;
        default:            state_d = IF_REQ;
      endcase
    end else begin
      if (stall) begin
        if_valid_d = if_valid;
        if_inst_d  = if_inst;
      end else if (skid_full) begin
        skid_pop   = 1'b1;
        if_valid_d = 1'b1;
        if_pc_d    = skid_out.pc;
        if_inst_d  = skid_out.inst;
      end

      if (accept) begin
        if (state_q == IF_DISCARD) begin
          state_d = IF_REQ;
        end else begin
          pc_d = pc_q + XLEN'(4);
          if (stall) begin
            skid_push = 1'b1;
            state_d   = IF_IDLE;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = addr_q;
            if_inst_d  = imem.imem_rdata;
          end
        end
      end else if (state_q == IF_IDLE && (!skid_full || !stall)) begin
        state_d = IF_REQ;
      end
    end

    // An unaccepted request keeps its address even after the PC is redirected.
    addr_d = (state_d == IF_DISCARD) ? addr_q : pc_d;
    req_d  = (state_d != IF_IDLE);
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: correct-path fetch stream model plus directed corners.
module tb_fetch_redirect_unit;
  import fetch_redirect_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  model_pc;
  logic         prev_pending;
  logic [31:0]  prev_addr;
  logic [31:0]  held_addr;

  fetch_redirect_unit_if bus();

  fetch_redirect_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the architectural model records which accepted word is correct-path.
  task automatic step(input logic st, input logic jf, input logic [31:0] tgt, input logic rdy);
    logic [31:0] t;
    @(posedge clk);
    #1;
    t = tgt;
    if (jf && ((t & ~32'd3) == bus.imem_addr)) t = t ^ 32'h10;
    stall           = st;
    jump_flag       = jf;
    jump_target     = t;
    bus.imem_ready  = rdy;
    bus.imem_rdata  = mem_word(bus.imem_addr);
    if (jf) begin
      exp_q.delete();
      model_pc = t & ~32'd3;
    end else if (bus.imem_req && rdy && bus.imem_addr == model_pc) begin
      exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Monitor: every instruction ID consumes must be the next correct-path word.
  always @(negedge clk) begin : monitor
    fetch_entry_t e;
    if (!rst_n) begin
      prev_pending <= 1'b0;
    end else begin
      check("flush_follows_jump", 32'(flush), 32'(jump_flag));
      if (!if_valid) check("nop_when_invalid", if_inst, NOP);
      if (prev_pending) begin
        check("req_held", 32'(bus.imem_req), 32'd1);
        check("addr_held", bus.imem_addr, prev_addr);
      end
      if (if_valid && !stall && !jump_flag) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(if_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_inst", if_inst, e.inst);
        end
      end
      prev_pending <= bus.imem_req && !bus.imem_ready;
      prev_addr    <= bus.imem_addr;
    end
  end

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    jump_flag      = 1'b0;
    jump_target    = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    model_pc       = RST_PC;
    prev_pending   = 1'b0;
    prev_addr      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch with an always-ready memory
    step(0, 0, 0, 1); check("seq_addr0", bus.imem_addr, 32'h0); check("seq_req", 32'(bus.imem_req), 32'd1);
    step(0, 0, 0, 1); check("seq_addr4", bus.imem_addr, 32'h4); check("seq_valid", 32'(if_valid), 32'd1);
    step(0, 0, 0, 1); check("seq_addr8", bus.imem_addr, 32'h8);
    step(0, 0, 0, 1); check("seq_addr12", bus.imem_addr, 32'hC);

    // Redirect while the request is accepted
    step(0, 1, 32'h0000_0103, 1);
    step(0, 0, 0, 1); check("redir_addr", bus.imem_addr, 32'h100); check("redir_bubble", 32'(if_valid), 32'd0);

    // Redirect while the request is still pending
    step(0, 1, 32'h0000_3002, 0); held_addr = bus.imem_addr;
    step(0, 0, 0, 0); check("disc_addr1", bus.imem_addr, held_addr); check("disc_req", 32'(bus.imem_req), 32'd1);
    step(0, 0, 0, 0); check("disc_addr2", bus.imem_addr, held_addr);
    step(0, 0, 0, 1); check("disc_addr3", bus.imem_addr, held_addr);
    step(0, 0, 0, 1); check("disc_target", bus.imem_addr, 32'h3000);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1); check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1); check("wrap_zero", bus.imem_addr, 32'h0);
    step(0, 0, 0, 1);

    // Stall fills the skid and halts requests; release drains in order
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1); check("stall_no_req", 32'(bus.imem_req), 32'd0);
    end
    repeat (4) step(0, 0, 0, 1);

    // Redirect during stall with a full skid
    step(1, 0, 0, 1);
    step(1, 0, 0, 1); check("full_no_req", 32'(bus.imem_req), 32'd0);
    step(1, 1, 32'h0000_2000, 1);
    step(0, 0, 0, 1); check("jstall_bubble", 32'(if_valid), 32'd0); check("jstall_addr", bus.imem_addr, 32'h2000);
    repeat (2) step(0, 0, 0, 1);

    // Asynchronous reset while a request is outstanding
    step(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.imem_req), 32'd0);
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_inst", if_inst, NOP);
    exp_q.delete();
    model_pc       = RST_PC;
    bus.imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    repeat (8) step(0, 0, 0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
